uart_baud_gen: RTL and testbench
================================

UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter DIV_W, default 16: width of the integer divisor.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor; 0 is not permitted.
REQ-003 Parameter OSR, default 16: oversampling ratio; it SHALL be a power of 2 and at least 4, and elaboration SHALL fail otherwise.
REQ-004 baud_clk  input  1  module clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  run enable; while low, all state SHALL hold.
REQ-007 load  input  1  single-cycle pulse that captures div_int/div_frac into the shadow divisor.
REQ-008 div_int  input  DIV_W  integer divisor, in baud_clk cycles per oversample tick.
REQ-009 div_frac  input  FRAC_W  fractional divisor, in units of 2^-FRAC_W cycles.
REQ-010 restart  input  1  single-cycle pulse that realigns the phase (RX start-bit alignment).
REQ-011 os_tick  output  1  oversample strobe, one cycle wide.
REQ-012 mid_tick  output  1  strobe at the bit centre, one cycle wide.
REQ-013 bit_tick  output  1  strobe at the bit boundary, one cycle wide.
REQ-014 baud_out  output  1  square wave at the bit rate with a 50% duty cycle, measured in os_ticks.

Function
REQ-015 The block SHALL hold these registered state elements: active divisor (act_int, act_frac), pending shadow divisor with a pend flag, down-counter cnt[DIV_W], fractional accumulator acc[FRAC_W], and oversample counter os_cnt[log2(OSR)].
REQ-016 The period P of each os_tick interval SHALL be act_int, plus 1 if the acc update at the previous os_tick carried out of FRAC_W bits.
REQ-017 At each os_tick, acc SHALL update to (acc + act_frac) mod 2^FRAC_W.
REQ-018 The first interval after reset or restart SHALL have acc=0 and no carry, so P=act_int.
REQ-019 With en high and act_int>=1, os_tick SHALL be high for exactly 1 cycle every P cycles; the first os_tick SHALL follow P rising edges after the first edge on which en is sampled high.
REQ-020 If act_int=0, the block SHALL treat the divisor as invalid: os_tick, mid_tick and bit_tick SHALL stay 0, and cnt, acc and os_cnt SHALL hold at 0.
REQ-021 os_cnt SHALL increment on each os_tick and wrap from OSR-1 to 0.
REQ-022 bit_tick SHALL equal os_tick AND (os_cnt==OSR-1), using the pre-increment value of os_cnt.
REQ-023 mid_tick SHALL equal os_tick AND (os_cnt==OSR/2-1), using the pre-increment value of os_cnt.
REQ-024 baud_out SHALL toggle on every cycle in which mid_tick or bit_tick is high; its period SHALL be OSR os_ticks.
REQ-025 When load is high, the shadow SHALL capture div_int/div_frac and pend SHALL set.
REQ-026 When pend is set, the shadow SHALL be copied to act_* and pend SHALL clear, at the first of: the next os_tick, en low, or restart.
REQ-027 The new divisor SHALL never truncate an interval that is in progress.
REQ-028 A load arriving in the same cycle as a pending copy SHALL overwrite the shadow, and the newest value SHALL win.
REQ-029 On restart, cnt SHALL reload, acc and os_cnt SHALL clear to 0, baud_out SHALL clear to 0, and no tick SHALL be produced that cycle.
REQ-030 restart SHALL take effect regardless of en.
REQ-031 If load and restart are high in the same cycle, the new div_int/div_frac SHALL become active immediately, and the next interval SHALL use the new act_int.
REQ-032 If os_tick would fire in the same cycle as restart, restart SHALL win and the tick SHALL be suppressed.
REQ-033 While en is low, os_tick, mid_tick and bit_tick SHALL be 0, and cnt, acc, os_cnt and baud_out SHALL hold.
REQ-034 When en rises again, the interval that was in progress SHALL resume from the held cnt value.
REQ-035 All outputs SHALL be driven from flops; there SHALL be no combinational path from any input to any output.

Reset
REQ-036 While reset is high: act_int=1, act_frac=0, shadow=0, pend=0, cnt=0, acc=0, os_cnt=0, and os_tick=mid_tick=bit_tick=baud_out=0.
REQ-037 Assertion of reset SHALL take effect immediately, including in the middle of an interval.
REQ-038 After reset deasserts, the first edge with en high SHALL begin a fresh interval using act_int=1.

Verification
REQ-039 Scenario, integer divisor: load div_int=3, div_frac=0, then restart, then en=1 -> os_tick every 3 cycles, mid_tick at os_tick #8, bit_tick every 48 cycles, baud_out period 48 cycles high/low 24/24.
REQ-040 Scenario, fractional divisor: div_int=3, div_frac=8 (FRAC_W=4) -> interval lengths 3,3,4,3,4,3,4..., giving 112 cycles per 32 os_ticks.
REQ-041 Scenario, reload mid-interval: with div_int=5 and cnt mid-interval, load div_int=2 -> the current interval completes at 5 cycles, subsequent intervals are 2 cycles, and no glitch or double tick occurs.
REQ-042 Scenario, restart collision: restart asserted in the cycle an os_tick is due -> no tick in that cycle, os_cnt=0, baud_out=0, next os_tick exactly act_int cycles later.
REQ-043 Scenario, enable pause: en low for 10 cycles mid-interval, then high -> ticks are 0 during the pause and the interval resumes with its remaining cycles.
REQ-044 Scenario, reset and invalid divisor: reset pulse mid-interval -> all outputs 0 immediately; then div_int=0 loaded -> no ticks for 100 cycles.

Source files
------------

// File: rtl/uart_baud_gen.sv
// Fractional baud-rate generator: produces oversample, bit-centre and bit-boundary
// strobes plus a bit-rate square wave from baud_clk, with glitch-free divisor reload.
module uart_baud_gen #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR    = 16
) (
    input  logic              baud_clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              restart_i,
    output logic              os_tick_o,
    output logic              mid_tick_o,
    output logic              bit_tick_o,
    output logic              baud_out_o
);
    localparam int OS_W = $clog2(OSR);

    generate
        if (FRAC_W < 1) begin : g_bad_frac
            $error("uart_baud_gen: FRAC_W must be at least 1");
        end
        if ((OSR < 4) || ((OSR & (OSR - 1)) != 0)) begin : g_bad_osr
            $error("uart_baud_gen: OSR must be a power of 2 and at least 4");
        end
    endgenerate

    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic              os_tick_q, os_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              baud_q, baud_d;

    logic              valid;
    logic              fire;
    logic              copy;
    logic [FRAC_W:0]   acc_sum;

    // cnt holds the edges still to go in the current interval minus one; the
    // tick fires on the edge that finds it at zero, then the next length is loaded.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        baud_d     = baud_q;
        os_tick_d  = 1'b0;
        mid_tick_d = 1'b0;
        bit_tick_d = 1'b0;

        valid   = (act_int_q != '0);
        fire    = en_i && valid && !restart_i && (cnt_q == '0);
        copy    = pend_q && (fire || !en_i || restart_i);
        acc_sum = {1'b0, acc_q} + {1'b0, act_frac_q};

        if (copy) begin
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            pend_d     = 1'b0;
        end
        if (load_i) begin
            sh_int_d  = div_int_i;
            sh_frac_d = div_frac_i;
            pend_d    = 1'b1;
        end

        if (restart_i) begin
            // A divisor loaded together with restart bypasses the shadow.
            if (load_i) begin
                act_int_d  = div_int_i;
                act_frac_d = div_frac_i;
                pend_d     = 1'b0;
            end
            cnt_d    = (act_int_d == '0) ? '0 : act_int_d - DIV_W'(1);
            acc_d    = '0;
            os_cnt_d = '0;
            baud_d   = 1'b0;
        end else if (!valid) begin
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
        end else if (en_i) begin
            if (fire) begin
                os_tick_d  = 1'b1;
                mid_tick_d = (os_cnt_q == OS_W'(OSR / 2 - 1));
                bit_tick_d = (os_cnt_q == OS_W'(OSR - 1));
                os_cnt_d   = os_cnt_q + OS_W'(1);
                acc_d      = acc_sum[FRAC_W-1:0];
                cnt_d      = (act_int_d == '0) ? '0
                           : act_int_d - DIV_W'(1) + DIV_W'(acc_sum[FRAC_W]);
                baud_d     = baud_q ^ (mid_tick_d | bit_tick_d);
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            act_int_q  <= DIV_W'(1);
            act_frac_q <= '0;
            sh_int_q   <= '0;
            sh_frac_q  <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            mid_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            baud_q     <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            os_tick_q  <= os_tick_d;
            mid_tick_q <= mid_tick_d;
            bit_tick_q <= bit_tick_d;
            baud_q     <= baud_d;
        end
    end

    assign os_tick_o  = os_tick_q;
    assign mid_tick_o = mid_tick_q;
    assign bit_tick_o = bit_tick_q;
    assign baud_out_o = baud_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: vector table, directed multi-cycle scenarios and a
// randomized run against an interval-length reference model.
module tb_uart_baud_gen;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR    = 16;

    logic              baud_clk = 1'b0;
    logic              reset;
    logic              en, load, restart;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              os_tick, mid_tick, bit_tick, baud_out;

    int checks   = 0;
    int failures = 0;

    uart_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR)) dut (
        .baud_clk   (baud_clk),
        .reset      (reset),
        .en_i       (en),
        .load_i     (load),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .restart_i  (restart),
        .os_tick_o  (os_tick),
        .mid_tick_o (mid_tick),
        .bit_tick_o (bit_tick),
        .baud_out_o (baud_out)
    );

    always #5 baud_clk = ~baud_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {os_tick, mid_tick, bit_tick, baud_out};
    endfunction

    task automatic cycle();
        @(posedge baud_clk);
        #1;
    endtask

    // ---------------- reference model: interval lengths and tick numbers ----
    int m_int, m_frac, m_sh, m_shf, m_pend;
    int m_elapsed, m_len, m_acc, m_k, m_baud;
    logic [3:0] m_exp;

    function automatic void model_reset();
        m_int = 1; m_frac = 0; m_sh = 0; m_shf = 0; m_pend = 0;
        m_elapsed = 0; m_len = 1; m_acc = 0; m_k = 0; m_baud = 0;
        m_exp = 4'b0000;
    endfunction

    function automatic void model_step();
        int tick, mid, bt, copy, carry;
        if (restart) begin
            if (load) begin
                m_int = int'(div_int); m_frac = int'(div_frac);
                m_sh = m_int; m_shf = m_frac; m_pend = 0;
            end else if (m_pend != 0) begin
                m_int = m_sh; m_frac = m_shf; m_pend = 0;
            end
            m_acc = 0; m_k = 0; m_baud = 0; m_elapsed = 0; m_len = m_int;
            m_exp = 4'b0000;
            return;
        end
        tick = (en && m_int != 0 && m_elapsed + 1 == m_len) ? 1 : 0;
        mid  = (tick != 0 && (m_k % OSR) == OSR / 2 - 1) ? 1 : 0;
        bt   = (tick != 0 && (m_k % OSR) == OSR - 1) ? 1 : 0;
        if (en && m_int != 0) m_elapsed++;
        copy = (m_pend != 0 && (tick != 0 || !en)) ? 1 : 0;
        if (tick != 0) begin
            carry = (m_acc + m_frac >= (1 << FRAC_W)) ? 1 : 0;
            m_acc = (m_acc + m_frac) % (1 << FRAC_W);
            m_k++;
            if (mid != 0 || bt != 0) m_baud = 1 - m_baud;
            m_len = ((copy != 0) ? m_sh : m_int) + carry;
            m_elapsed = 0;
        end
        if (copy != 0) begin
            m_int = m_sh; m_frac = m_shf; m_pend = 0;
        end
        if (load) begin
            m_sh = int'(div_int); m_shf = int'(div_frac); m_pend = 1;
        end
        m_exp = {tick[0], mid[0], bt[0], m_baud[0]};
    endfunction

    // ---------------- capture helpers ---------------------------------------
    logic [3:0] cap [0:255];

    task automatic capture(input int n, input int ld_at, input int ld_val, input int rs_at);
        for (int i = 0; i < n; i++) begin
            load    = (i == ld_at);
            if (i == ld_at) div_int = DIV_W'(ld_val);
            restart = (i == rs_at);
            cycle();
            cap[i] = outs();
        end
        load    = 1'b0;
        restart = 1'b0;
    endtask

    function automatic int find_nth(input int b, input int n, input int from);
        int seen = 0;
        for (int i = from; i < 256; i++) begin
            if (cap[i][b] === 1'b1) begin
                seen++;
                if (seen == n) return i;
            end
        end
        return -1;
    endfunction

    function automatic int find_level(input int b, input logic v, input int from);
        for (int i = from; i < 256; i++)
            if (cap[i][b] === v) return i;
        return -1;
    endfunction

    function automatic int count_set(input int b, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++)
            if (cap[i][b] === 1'b1) c++;
        return c;
    endfunction

    task automatic do_reset();
        en = 1'b0; load = 1'b0; restart = 1'b0; div_int = '0; div_frac = '0;
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 256; i++) cap[i] = 4'b0000;
    endtask

    task automatic setup_div(input int di, input int df);
        load = 1'b1; div_int = DIV_W'(di); div_frac = FRAC_W'(df);
        cycle();
        load = 1'b0; restart = 1'b1;
        cycle();
        restart = 1'b0; en = 1'b1;
    endtask

    typedef struct {
        logic              en;
        logic              load;
        logic              restart;
        logic [DIV_W-1:0]  di;
        logic [FRAC_W-1:0] df;
        logic [3:0]        exp;
    } vec_t;

    vec_t tbl [25];

    initial begin
        int bad, prev, r1, f1, r2, t1, t2, t3, t32, t33, w;

        // {en, load, restart, div_int, div_frac, expected {os,mid,bit,baud}}
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'd3, 4'd0, 4'b0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b1000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b1000};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'd3, 4'd0, 4'b0000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b1000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b0000};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 16'd3, 4'd0, 4'b1000};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 16'd1, 4'd0, 4'b0000};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 16'd1, 4'd0, 4'b1000};
        tbl[20] = '{1'b1, 1'b0, 1'b0, 16'd1, 4'd0, 4'b1000};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 16'd0, 4'd0, 4'b1000};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 4'b1000};
        tbl[23] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 4'b0000};
        tbl[24] = '{1'b1, 1'b0, 1'b0, 16'd0, 4'd0, 4'b0000};

        en = 1'b0; load = 1'b0; restart = 1'b0; div_int = '0; div_frac = '0;
        reset = 1'b1;
        cycle();
        check("reset_outs", 32'(outs()), 32'(4'b0000));
        do_reset();

        for (int i = 0; i < 25; i++) begin
            en = tbl[i].en; load = tbl[i].load; restart = tbl[i].restart;
            div_int = tbl[i].di; div_frac = tbl[i].df;
            cycle();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Integer divisor 3: tick spacing, bit centre, bit boundary, baud duty
        do_reset();
        setup_div(3, 0);
        capture(200, -1, 0, -1);
        bad = 0; prev = -1;
        for (int i = 0; i < 200; i++) begin
            if (cap[i][3] === 1'b1) begin
                if (prev >= 0 && i - prev != 3) bad++;
                prev = i;
            end
        end
        check("int_os_gaps", 32'(bad), 32'(0));
        check("int_os_count", 32'(count_set(3, 0, 199)), 32'(66));
        check("int_first_os", 32'(find_nth(3, 1, 0)), 32'(2));
        check("int_first_mid", 32'(find_nth(2, 1, 0)), 32'(23));
        check("int_first_bit", 32'(find_nth(1, 1, 0)), 32'(47));
        check("int_bit_period", 32'(find_nth(1, 2, 0) - find_nth(1, 1, 0)), 32'(48));
        r1 = find_level(0, 1'b1, 0);
        f1 = find_level(0, 1'b0, r1 < 0 ? 255 : r1);
        r2 = find_level(0, 1'b1, f1 < 0 ? 255 : f1);
        check("int_baud_rise", 32'(r1), 32'(23));
        check("int_baud_high", 32'(f1 - r1), 32'(24));
        check("int_baud_low", 32'(r2 - f1), 32'(24));

        // Fractional divisor 3 + 8/16
        do_reset();
        setup_div(3, 8);
        capture(200, -1, 0, -1);
        t1 = find_nth(3, 1, 0); t2 = find_nth(3, 2, 0); t3 = find_nth(3, 3, 0);
        t32 = find_nth(3, 32, 0); t33 = find_nth(3, 33, 0);
        check("frac_gap2", 32'(t2 - t1), 32'(3));
        check("frac_gap3", 32'(t3 - t2), 32'(4));
        check("frac_32_ticks_from_start", 32'(t32 + 1), 32'(111));
        check("frac_32_intervals_steady", 32'(t33 - t1), 32'(112));

        // Reload mid-interval: 5 -> 2
        do_reset();
        setup_div(5, 0);
        capture(20, 2, 2, -1);
        check("reload_first", 32'(find_nth(3, 1, 0)), 32'(4));
        check("reload_second", 32'(find_nth(3, 2, 0)), 32'(6));
        check("reload_count", 32'(count_set(3, 0, 10)), 32'(4));

        // Restart colliding with a due tick
        do_reset();
        setup_div(4, 0);
        capture(60, -1, 0, 7);
        check("coll_no_tick", 32'(cap[7][3]), 32'(0));
        check("coll_baud", 32'(cap[7][0]), 32'(0));
        check("coll_next_tick", 32'(find_nth(3, 1, 8)), 32'(11));
        check("coll_count", 32'(count_set(3, 0, 11)), 32'(2));
        check("coll_mid_realigned", 32'(find_nth(2, 1, 8)), 32'(39));

        // Async reset mid-run, then an invalid divisor
        do_reset();
        setup_div(1, 0);
        w = 0;
        while (baud_out !== 1'b1 && w < 100) begin
            cycle();
            w++;
        end
        check("rst_pre_baud", 32'(baud_out), 32'(1));
        check("rst_pre_os", 32'(os_tick), 32'(1));
        @(negedge baud_clk);
        reset = 1'b1; en = 1'b0;
        #1;
        check("rst_immediate", 32'(outs()), 32'(4'b0000));
        cycle();
        reset = 1'b0;
        load = 1'b1; div_int = '0; div_frac = '0;
        cycle();
        load = 1'b0;
        cycle();
        en = 1'b1;
        capture(100, -1, 0, -1);
        check("inv_no_os", 32'(count_set(3, 0, 99)), 32'(0));
        check("inv_no_strobes", 32'(count_set(2, 0, 99) + count_set(1, 0, 99)), 32'(0));

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 99) < 85);
            load     = ($urandom_range(0, 99) < 5);
            restart  = ($urandom_range(0, 99) < 1);
            div_int  = DIV_W'($urandom_range(1, 4));
            div_frac = FRAC_W'($urandom_range(0, 15));
            @(posedge baud_clk);
            model_step();
            #1;
            check("rand_outs", 32'(outs()), 32'(m_exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
